// File: rtl/key_entry_pkg.sv
// Shared constants for the keypad entry/display slice: key codes, FSM states
// and active-low 7-segment patterns in {g,f,e,d,c,b,a} order.
package key_entry_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    SHOWN = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/key_entry_display_seg7.sv
// seg7_decode: combinational BCD to active-low segment lookup with blank and
// dash overrides; the parent registers the result.
module seg7_decode
  import key_entry_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Dash wins over blank; non-BCD nibbles cannot occur but decode as blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/key_entry_display.sv
// Keypad entry buffer with commit/clear and a multiplexed 4-digit display.
// Define KEY_ENTRY_ZPAD_EN to show leading-zero padding instead of blanking/dash.
module key_entry_display
  import key_entry_pkg::*;
#(
  parameter int SCAN_DIV = 14
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_vld,
  output logic [6:0]  seg,
  output logic [3:0]  dig,
  output logic [15:0] value,
  output logic        value_vld
);

  localparam logic [SCAN_DIV-1:0] DIV_ONE = 1;

  state_e              state_q;
  logic [15:0]         buffer_q;
  logic [2:0]          count_q;
  logic [15:0]         value_q;
  logic                value_vld_q;
  logic [SCAN_DIV-1:0] div_q;
  logic [1:0]          slot_q, slot_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          dig_q, dig_d;

  logic                isDigit;
  logic                wrap;
  logic [1:0]          nextSlot;
  logic [3:0]          nibble;
  logic                blankSel;
  logic                dashSel;
  logic [6:0]          segNext;

  assign isDigit = (key_code <= 4'd9);

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q     <= EMPTY;
      buffer_q    <= 16'h0000;
      count_q     <= 3'd0;
      value_q     <= 16'h0000;
      value_vld_q <= 1'b0;
    end else begin
      value_vld_q <= 1'b0;
      if (key_vld) begin
        case (state_q)
          EMPTY: begin
            if (isDigit) begin
              buffer_q <= {12'h000, key_code};
              count_q  <= 3'd1;
              state_q  <= ENTRY;
            end
          end
          ENTRY: begin
            if (isDigit) begin
              if (count_q < 3'd4) begin
                buffer_q <= {buffer_q[11:0], key_code};
                count_q  <= count_q + 3'd1;
              end
            end else if (key_code == KEY_STAR) begin
              buffer_q <= 16'h0000;
              count_q  <= 3'd0;
              state_q  <= EMPTY;
            end else if (key_code == KEY_HASH) begin
              value_q     <= buffer_q;
              value_vld_q <= 1'b1;
              state_q     <= SHOWN;
            end
          end
          SHOWN: begin
            if (isDigit) begin
              buffer_q <= {12'h000, key_code};
              count_q  <= 3'd1;
              state_q  <= ENTRY;
            end else if (key_code == KEY_STAR) begin
              buffer_q <= 16'h0000;
              count_q  <= 3'd0;
              state_q  <= EMPTY;
            end else if (key_code == KEY_HASH) begin
              value_q     <= buffer_q;
              value_vld_q <= 1'b1;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign wrap     = &div_q;
  assign nextSlot = slot_q + 2'd1;

  // In SHOWN the buffer still holds the committed entry, so count_q remains its
  // digit count and blanks the same leading slots as during entry.
  always_comb begin
    nibble   = 4'h0;
    blankSel = 1'b0;
    dashSel  = 1'b0;
    case (state_q)
      ENTRY: begin
        nibble = buffer_q[{nextSlot, 2'b00} +: 4];
`ifndef KEY_ENTRY_ZPAD_EN
        blankSel = ({1'b0, nextSlot} >= count_q);
`endif
      end
      SHOWN: begin
        nibble = value_q[{nextSlot, 2'b00} +: 4];
`ifndef KEY_ENTRY_ZPAD_EN
        blankSel = ({1'b0, nextSlot} >= count_q);
`endif
      end
      default: begin
`ifdef KEY_ENTRY_ZPAD_EN
        nibble = 4'h0;
`else
        dashSel  = (nextSlot == 2'd0);
        blankSel = (nextSlot != 2'd0);
`endif
      end
    endcase
  end

  seg7_decode u_seg7 (
    .bcd_i   (nibble),
    .blank_i (blankSel),
    .dash_i  (dashSel),
    .seg_o   (segNext)
  );

  always_comb begin
    slot_d = slot_q;
    seg_d  = seg_q;
    dig_d  = dig_q;
    if (wrap) begin
      slot_d = nextSlot;
      seg_d  = segNext;
      dig_d  = 4'b0001 << nextSlot;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      div_q  <= '0;
      slot_q <= 2'd0;
      seg_q  <= SEG_BLANK;
      dig_q  <= 4'b0001;
    end else begin
      div_q  <= div_q + DIV_ONE;
      slot_q <= slot_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign seg       = seg_q;
  assign dig       = dig_q;
  assign value     = value_q;
  assign value_vld = value_vld_q;

endmodule

// File: tb/tb_key_entry_display.sv
// Directed bench for key_entry_display with SCAN_DIV = 2 (4 cycles per slot).
// Expectations follow KEY_ENTRY_ZPAD_EN when the macro is defined.
module tb_key_entry_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic        ck;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_vld;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic        value_vld;

  int testCount = 0;
  int failCount = 0;
  int vldPulses = 0;
  int vldMark;

  key_entry_display #(.SCAN_DIV(2)) dut (
    .ck        (ck),
    .rst       (rst),
    .key_code  (key_code),
    .key_vld   (key_vld),
    .seg       (seg),
    .dig       (dig),
    .value     (value),
    .value_vld (value_vld)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(negedge ck) if (value_vld) vldPulses++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One key strobe; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [3:0] code);
    key_code = code;
    key_vld  = 1'b1;
    @(posedge ck); #1;
    key_vld  = 1'b0;
  endtask

  // Let the display settle for a full rotation, then record seg per enabled digit.
  task automatic checkDisplay(input string tag, input logic [27:0] expected);
    logic [27:0] seen;
    int badDig;
    seen   = '0;
    badDig = 0;
    repeat (16) @(posedge ck);
    for (int i = 0; i < 16; i++) begin
      @(posedge ck); #1;
      case (dig)
        4'b0001: seen[6:0]   = seg;
        4'b0010: seen[13:7]  = seg;
        4'b0100: seen[20:14] = seg;
        4'b1000: seen[27:21] = seg;
        default: badDig++;
      endcase
    end
    checkOutput({tag, "_onehot"}, badDig, 0);
    checkOutput(tag, {4'h0, seen}, {4'h0, expected});
  endtask

  logic [27:0] expEmpty, exp07;

  initial begin
`ifdef KEY_ENTRY_ZPAD_EN
    expEmpty = {S0, S0, S0, S0};
    exp07    = {S0, S0, S0, S7};
`else
    expEmpty = {SB, SB, SB, SD};
    exp07    = {SB, SB, S0, S7};
`endif
    rst = 1'b1; key_vld = 1'b0; key_code = 4'h0;
    repeat (2) @(posedge ck); #1;
    checkOutput("rst_seg", seg, SB);
    checkOutput("rst_dig", dig, 4'b0001);
    checkOutput("rst_value", value, 16'h0000);
    checkOutput("rst_vld", value_vld, 1'b0);
    rst = 1'b0;
    checkDisplay("disp_empty", expEmpty);

    vldMark = vldPulses;
    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3);
    applyStimulus(4'd4); applyStimulus(4'd11);
    checkOutput("commit_vld_hi", value_vld, 1'b1);
    checkOutput("commit_value", value, 16'h1234);
    @(posedge ck); #1;
    checkOutput("commit_vld_lo", value_vld, 1'b0);
    checkOutput("commit_pulses", vldPulses - vldMark, 1);
    checkDisplay("disp_1234", {S1, S2, S3, S4});

    applyStimulus(4'd11);
    checkOutput("recommit_vld", value_vld, 1'b1);
    checkOutput("recommit_value", value, 16'h1234);

    applyStimulus(4'd5); applyStimulus(4'd6); applyStimulus(4'd7);
    applyStimulus(4'd8); applyStimulus(4'd9);
    checkDisplay("disp_5678", {S5, S6, S7, S8});
    checkOutput("entry_value_kept", value, 16'h1234);
    applyStimulus(4'd10);
    checkDisplay("disp_star", expEmpty);
    checkOutput("star_value_kept", value, 16'h1234);

    applyStimulus(4'd0); applyStimulus(4'd7); applyStimulus(4'd11);
    checkOutput("commit07_value", value, 16'h0007);
    checkDisplay("disp_07", exp07);

    applyStimulus(4'd10);
    vldMark = vldPulses;
    applyStimulus(4'd12); applyStimulus(4'd15); applyStimulus(4'd11);
    @(posedge ck); #1;
    checkOutput("empty_no_vld", vldPulses - vldMark, 0);
    checkOutput("empty_value", value, 16'h0007);
    checkDisplay("disp_empty_ign", expEmpty);

    applyStimulus(4'd2);
    rst = 1'b1; key_code = 4'd3; key_vld = 1'b1;
    @(posedge ck); #1;
    key_vld = 1'b0;
    checkOutput("midrst_seg", seg, SB);
    checkOutput("midrst_dig", dig, 4'b0001);
    checkOutput("midrst_value", value, 16'h0000);
    checkOutput("midrst_vld", value_vld, 1'b0);
    rst = 1'b0;
    checkDisplay("disp_after_rst", expEmpty);
    vldMark = vldPulses;
    applyStimulus(4'd11);
    @(posedge ck); #1;
    checkOutput("after_rst_no_vld", vldPulses - vldMark, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
